column_scan_ctrl: RTL and testbench

Sequential readout controller that sits directly downstream of the 16:1 column-select mux in the Phase2 4-bit datapath. It drives the mux's 4-bit column select, samples the selected bit once per cycle over a programmable column range, and assembles the bits into a 16-bit word. The word is presented to the consumer through a valid/ack handshake. It turns the combinational bit selector into a multi-cycle word fetch with start/busy/done semantics.

---
 rtl/column_pkg.sv | 28 ++
 rtl/column_scan_ctrl.sv | 100 ++++++++++
 tb/tb_column_scan_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/column_pkg.sv
// Shared types and constants for the column readout controllers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: scan FSM state encoding, mux geometry constants and the
// scan-length helper that turns an inclusive column range into a count.
package column_pkg;

   localparam int NUM_COLS = 16;
   localparam int COL_W    = 4;
   localparam int CNT_W    = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      HOLD = 2'd2
   } state_t;

   // Number of columns in an inclusive range, wrapping modulo NUM_COLS.
   // first == last+1 yields the full 16-column scan, hence the 5-bit result.
   function automatic logic [CNT_W-1:0] scan_len(input logic [COL_W-1:0] first,
                                                 input logic [COL_W-1:0] last);
      logic [COL_W-1:0] diff;
      diff = last - first;
      return {1'b0, diff} + CNT_W'(1);
   endfunction

endpackage

// File: rtl/column_scan_ctrl.sv
// Sequential readout controller: steps the 16:1 column mux over a range and assembles a 16-bit word.
// Latency: WORD_VALID rises n cycles after the START edge (n = columns in range, 1..16).
// Backpressure: WORD is held with WORD_VALID until ACK; START is ignored until then (no queuing).
//
// Ports:
//   CLK, RESET            clock and asynchronous active-high reset
//   START, FIRST_COL,     scan request and inclusive column range, sampled in IDLE
//   LAST_COL              or in HOLD together with ACK
//   MUX_BIT               bit returned by the mux for the driven COLUMN
//   COLUMN                column select to the mux (0 outside SCAN)
//   BUSY                  high in SCAN and HOLD
//   WORD, WORD_VALID, ACK assembled word and its valid/ack handshake
module column_scan_ctrl
   import column_pkg::*;
(
   input  logic                CLK,
   input  logic                RESET,
   input  logic                START,
   input  logic [COL_W-1:0]    FIRST_COL,
   input  logic [COL_W-1:0]    LAST_COL,
   input  logic                MUX_BIT,
   output logic [COL_W-1:0]    COLUMN,
   output logic                BUSY,
   output logic [NUM_COLS-1:0] WORD,
   output logic                WORD_VALID,
   input  logic                ACK
);

   state_t              state;
   state_t              state_nxt;
   logic                load;
   logic [COL_W-1:0]    ptr;
   logic [CNT_W-1:0]    cnt;
   logic [NUM_COLS-1:0] word;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // load marks the edge at which a new range is latched: from IDLE, or
   // straight out of HOLD when the consumer acks and re-requests together.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         IDLE: begin
            if (START) begin
               load      = 1'b1;
               state_nxt = SCAN;
            end
         end
         SCAN: begin
            if (cnt == CNT_W'(1)) begin
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (ACK) begin
               if (START) begin
                  load      = 1'b1;
                  state_nxt = SCAN;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         ptr  <= '0;
         cnt  <= '0;
         word <= '0;
      end else if (load) begin
         ptr  <= FIRST_COL;
         cnt  <= scan_len(FIRST_COL, LAST_COL);
         word <= '0;
      end else if (state == SCAN) begin
         // OR-in the sampled bit; WORD was cleared on load so out-of-range
         // columns stay 0. The pointer wraps naturally at 4 bits.
         word <= word | (NUM_COLS'(MUX_BIT) << ptr);
         ptr  <= ptr + COL_W'(1);
         cnt  <= cnt - CNT_W'(1);
      end
   end

   assign COLUMN     = (state == SCAN) ? ptr : '0;
   assign BUSY       = (state != IDLE);
   assign WORD_VALID = (state == HOLD);
   assign WORD       = word;

endmodule

// File: tb/tb_column_scan_ctrl.sv
// Self-checking bench for column_scan_ctrl with a behavioural 16:1 mux on its select.
// Latency: n/a (testbench).
// Backpressure: ACK driven by the scenarios to exercise stall and back-to-back accept.
module tb_column_scan_ctrl;
   import column_pkg::*;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                start = 1'b0;
   logic [COL_W-1:0]    first_col = '0;
   logic [COL_W-1:0]    last_col = '0;
   logic                mux_bit;
   logic [COL_W-1:0]    column;
   logic                busy;
   logic [NUM_COLS-1:0] word;
   logic                word_valid;
   logic                ack = 1'b0;
   logic [NUM_COLS-1:0] pattern = '0;

   int checks = 0;
   int errors = 0;
   logic [NUM_COLS-1:0] exp_q[$];

   always #5 clk = ~clk;

   // Behavioural stand-in for the combinational 16:1 column mux.
   assign mux_bit = pattern[column];

   column_scan_ctrl dut (
      .CLK       (clk),
      .RESET     (rst),
      .START     (start),
      .FIRST_COL (first_col),
      .LAST_COL  (last_col),
      .MUX_BIT   (mux_bit),
      .COLUMN    (column),
      .BUSY      (busy),
      .WORD      (word),
      .WORD_VALID(word_valid),
      .ACK       (ack)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch a scan (optionally as ack+start from HOLD), check the column
   // sequence and latency, then pop the scoreboard when WORD_VALID appears.
   task automatic run_scan(input logic [3:0] f, input logic [3:0] l,
                           input logic [15:0] pat, input logic [15:0] exp_word,
                           input bit with_ack, input string name);
      int n;
      logic [3:0] col;
      logic [15:0] got;
      n = int'((l - f) & 4'hF) + 1;
      pattern   = pat;
      first_col = f;
      last_col  = l;
      start     = 1'b1;
      ack       = with_ack;
      exp_q.push_back(exp_word);
      tick();
      start = 1'b0;
      ack   = 1'b0;
      for (int i = 0; i < n; i++) begin
         col = f + 4'(i);
         checks++;
         if (column !== col || busy !== 1'b1 || word_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s step%0d: column=%0d busy=%b valid=%b, required column=%0d busy=1 valid=0",
                     name, i, column, busy, word_valid, col);
         end
         tick();
      end
      checks++;
      if (word_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s latency: word_valid=%b after %0d cycles, required 1", name, word_valid, n);
      end else if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard: word_valid with empty queue, word=%h", name, word);
      end else begin
         got = exp_q.pop_front();
         if (word !== got) begin
            errors++;
            $display("FAIL %s word: got %h, required %h", name, word, got);
         end
      end
   endtask

   task automatic do_ack(input logic [15:0] exp_word, input string name);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      checks++;
      if (busy !== 1'b0 || word_valid !== 1'b0 || column !== 4'd0 || word !== exp_word) begin
         errors++;
         $display("FAIL %s ack->idle: busy=%b valid=%b column=%0d word=%h, required 0/0/0/%h",
                  name, busy, word_valid, column, word, exp_word);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2;
      checks++;
      if (busy !== 1'b0 || word_valid !== 1'b0 || column !== 4'd0 || word !== 16'h0) begin
         errors++;
         $display("FAIL reset_state: busy=%b valid=%b column=%0d word=%h, required all 0",
                  busy, word_valid, column, word);
      end
      tick();
      rst = 1'b0;
      tick();
      // Start a scan, let it collect some bits, then reset mid-scan.
      pattern = 16'hFFFF; first_col = 4'd0; last_col = 4'd15; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      checks++;
      if (busy !== 1'b1 || word === 16'h0) begin
         errors++;
         $display("FAIL reset_prescan: busy=%b word=%h, required busy=1 word nonzero", busy, word);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || word_valid !== 1'b0 || column !== 4'd0 || word !== 16'h0) begin
         errors++;
         $display("FAIL reset_midscan: busy=%b valid=%b column=%0d word=%h, required all 0",
                  busy, word_valid, column, word);
      end
      tick();
      rst = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0 || word_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: busy=%b valid=%b, required 0/0", busy, word_valid);
      end
   endtask

   task automatic test_full_scan();
      run_scan(4'd0, 4'd15, 16'hA5C3, 16'hA5C3, 1'b0, "full");
      do_ack(16'hA5C3, "full");
   endtask

   task automatic test_wrap();
      run_scan(4'd14, 4'd1, 16'hFFFF, 16'hC003, 1'b0, "wrap");
      do_ack(16'hC003, "wrap");
   endtask

   task automatic test_single();
      run_scan(4'd8, 4'd8, 16'h0100, 16'h0100, 1'b0, "single");
      do_ack(16'h0100, "single");
   endtask

   task automatic test_stall();
      logic [3:0] col;
      // Range 2..9 on all-ones; START pulses mid-scan must not disturb it.
      pattern = 16'hFFFF; first_col = 4'd2; last_col = 4'd9; start = 1'b1;
      exp_q.push_back(16'h03FC);
      tick();
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         col = 4'd2 + 4'(i);
         checks++;
         if (column !== col || busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_scan step%0d: column=%0d busy=%b, required %0d/1", i, column, busy, col);
         end
         if (i == 3) begin
            first_col = 4'd12; last_col = 4'd12; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         tick();
      end
      start = 1'b0;
      for (int c = 0; c < 10; c++) begin
         start = (c == 4);
         tick();
         checks++;
         if (word_valid !== 1'b1 || word !== 16'h03FC || column !== 4'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold cyc%0d: valid=%b word=%h column=%0d busy=%b, required 1/03fc/0/1",
                     c, word_valid, word, column, busy);
         end
      end
      start = 1'b0;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      do_ack(16'h03FC, "stall");
   endtask

   task automatic test_back_to_back();
      run_scan(4'd0, 4'd15, 16'h5A3C, 16'h5A3C, 1'b0, "b2b_first");
      // Ack and re-start in the same HOLD cycle: next cycle must be SCAN at column 4.
      run_scan(4'd4, 4'd7, 16'h00F0, 16'h00F0, 1'b1, "b2b_second");
      do_ack(16'h00F0, "b2b");
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, required finish before 100000");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_full_scan();
      test_wrap();
      test_single();
      test_stall();
      test_back_to_back();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d words left, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
